// File: rtl/pathtracer_io_pkg.sv
// Shared widths, beat counts and state encodings for the Pathtracer pad bridge.
package pathtracer_io_pkg;
  localparam int IN_W_DEF   = 12;
  localparam int PIN_W_DEF  = 4;
  localparam int OUT_W_DEF  = 24;
  localparam int POUT_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  localparam int NB_IN  = IN_W_DEF / PIN_W_DEF;
  localparam int NB_OUT = OUT_W_DEF / POUT_W_DEF;

  typedef enum logic {ASSEMBLE, HOLD} asm_state_e;
  typedef enum logic {IDLE, SEND}     ser_state_e;

  // Beat counter width: one spare bit so the count never overflows.
  function automatic int cnt_w(input int nb);
    return $clog2(nb) + 1;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with registered in_rdy and an occupancy counter.
module stream_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          flush,
  input  logic [W-1:0]  in_dat,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [LW-1:0] level
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    in_rdy_q, in_rdy_d;
  logic                    push, pop;

  // A push needs the registered rdy, so a pop in the same cycle cannot make room.
  assign push    = in_vld & in_rdy_q & ~flush;
  assign out_vld = (level_q != '0);
  assign pop     = out_rdy & out_vld & ~flush;
  assign out_dat = mem_q[rptr_q];
  assign in_rdy  = in_rdy_q;
  assign level   = level_q;

  // Pointer, level and ready next-state; flush clears everything.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
    in_rdy_d = (level_d != LW'(DEPTH));
  end

  // Control state; in_rdy stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_dat;
  end
endmodule

// File: rtl/gpio_stream_bridge.sv
// Pad <-> core bridge: inbound beat assembler, outbound FIFO and serialiser.
module gpio_stream_bridge
  import pathtracer_io_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int PIN_W  = PIN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int POUT_W = POUT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic [PIN_W-1:0]  pad_in_dat,
  input  logic              pad_in_vld,
  output logic              pad_in_rdy,
  output logic [IN_W-1:0]   core_in_dat,
  output logic              core_in_vld,
  input  logic              core_in_rdy,
  input  logic [OUT_W-1:0]  core_out_dat,
  input  logic              core_out_vld,
  output logic              core_out_rdy,
  output logic [POUT_W-1:0] pad_out_dat,
  output logic              pad_out_vld,
  output logic              pad_out_last,
  input  logic              pad_out_rdy,
  output logic [LW-1:0]     fifo_level
);
  localparam int NBI = IN_W / PIN_W;
  localparam int NBO = OUT_W / POUT_W;
  localparam int ICW = cnt_w(NBI);
  localparam int OCW = cnt_w(NBO);

  if (IN_W % PIN_W != 0) begin : g_bad_in_w
    $error("IN_W must be a multiple of PIN_W");
  end
  if (OUT_W % POUT_W != 0) begin : g_bad_out_w
    $error("OUT_W must be a multiple of POUT_W");
  end

  // ---------------- inbound assembler ----------------
  asm_state_e       asm_q, asm_d;
  logic [ICW-1:0]   icnt_q, icnt_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic             ivld_q, ivld_d, irdy_q, irdy_d;

  // Beats land LSB-first; the word register doubles as core_in_dat.
  always_comb begin
    asm_d  = asm_q;
    icnt_d = icnt_q;
    word_d = word_q;
    ivld_d = ivld_q;
    if (flush) begin
      asm_d  = ASSEMBLE;
      icnt_d = '0;
      ivld_d = 1'b0;
    end else if (asm_q == ASSEMBLE) begin
      if (pad_in_vld && irdy_q) begin
        word_d[icnt_q*PIN_W +: PIN_W] = pad_in_dat;
        if (icnt_q == ICW'(NBI-1)) begin
          icnt_d = '0;
          asm_d  = HOLD;
          ivld_d = 1'b1;
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end
    end else if (core_in_rdy) begin
      asm_d  = ASSEMBLE;
      ivld_d = 1'b0;
    end
    irdy_d = (asm_d == ASSEMBLE);
  end

  // Assembler registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      asm_q  <= ASSEMBLE;
      icnt_q <= '0;
      word_q <= '0;
      ivld_q <= 1'b0;
      irdy_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      icnt_q <= icnt_d;
      word_q <= word_d;
      ivld_q <= ivld_d;
      irdy_q <= irdy_d;
    end
  end

  assign pad_in_rdy  = irdy_q;
  assign core_in_dat = word_q;
  assign core_in_vld = ivld_q;

  // ---------------- outbound FIFO ----------------
  logic [OUT_W-1:0] fifo_dat;
  logic             fifo_vld, fifo_pop;

  stream_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .flush   (flush),
    .in_dat  (core_out_dat),
    .in_vld  (core_out_vld),
    .in_rdy  (core_out_rdy),
    .out_dat (fifo_dat),
    .out_vld (fifo_vld),
    .out_rdy (fifo_pop),
    .level   (fifo_level)
  );

  // ---------------- serialiser ----------------
  ser_state_e        ser_q, ser_d;
  logic [OCW-1:0]    ocnt_q, ocnt_d, ocnt_n;
  logic [OUT_W-1:0]  sh_q, sh_d;
  logic [POUT_W-1:0] odat_q, odat_d;
  logic              ovld_q, ovld_d, olast_q, olast_d;

  // Pops the head when idle or right after the last beat, so pixels go out with no bubble.
  always_comb begin
    ser_d    = ser_q;
    ocnt_d   = ocnt_q;
    sh_d     = sh_q;
    odat_d   = odat_q;
    ovld_d   = ovld_q;
    olast_d  = olast_q;
    fifo_pop = 1'b0;
    ocnt_n   = ocnt_q + 1'b1;
    if (flush) begin
      ser_d   = IDLE;
      ocnt_d  = '0;
      ovld_d  = 1'b0;
      olast_d = 1'b0;
    end else if (ser_q == IDLE || (pad_out_rdy && ocnt_q == OCW'(NBO-1))) begin
      if (fifo_vld) begin
        fifo_pop = 1'b1;
        ser_d    = SEND;
        sh_d     = fifo_dat;
        odat_d   = fifo_dat[POUT_W-1:0];
        ocnt_d   = '0;
        ovld_d   = 1'b1;
        olast_d  = (NBO == 1);
      end else begin
        ser_d   = IDLE;
        ovld_d  = 1'b0;
        olast_d = 1'b0;
      end
    end else if (pad_out_rdy) begin
      ocnt_d  = ocnt_n;
      odat_d  = sh_q[ocnt_n*POUT_W +: POUT_W];
      olast_d = (ocnt_n == OCW'(NBO-1));
    end
  end

  // Serialiser registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ser_q   <= IDLE;
      ocnt_q  <= '0;
      sh_q    <= '0;
      odat_q  <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      ser_q   <= ser_d;
      ocnt_q  <= ocnt_d;
      sh_q    <= sh_d;
      odat_q  <= odat_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
    end
  end

  assign pad_out_dat  = odat_q;
  assign pad_out_vld  = ovld_q;
  assign pad_out_last = olast_q;
endmodule

// File: tb/tb_gpio_stream_bridge.sv
// Directed bench for gpio_stream_bridge at default parameters.
module tb_gpio_stream_bridge;
  logic        clk = 1'b0;
  logic        arst_n, flush;
  logic [3:0]  pad_in_dat;
  logic        pad_in_vld, pad_in_rdy;
  logic [11:0] core_in_dat;
  logic        core_in_vld, core_in_rdy;
  logic [23:0] core_out_dat;
  logic        core_out_vld, core_out_rdy;
  logic [7:0]  pad_out_dat;
  logic        pad_out_vld, pad_out_last, pad_out_rdy;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_stream_bridge dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .pad_in_dat(pad_in_dat), .pad_in_vld(pad_in_vld), .pad_in_rdy(pad_in_rdy),
    .core_in_dat(core_in_dat), .core_in_vld(core_in_vld), .core_in_rdy(core_in_rdy),
    .core_out_dat(core_out_dat), .core_out_vld(core_out_vld), .core_out_rdy(core_out_rdy),
    .pad_out_dat(pad_out_dat), .pad_out_vld(pad_out_vld), .pad_out_last(pad_out_last),
    .pad_out_rdy(pad_out_rdy), .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] pix [5];
  logic [23:0] spix [3];
  logic [7:0]  exp_b [9];
  logic        acc;
  int          idx, cyc;

  initial begin
    pix[0] = 24'h112233; pix[1] = 24'h445566; pix[2] = 24'h778899;
    pix[3] = 24'hABCDEF; pix[4] = 24'h102030;
    spix[0] = 24'hC0FFEE; spix[1] = 24'h123456; spix[2] = 24'hDEAD01;
    arst_n = 1'b1; flush = 1'b0;
    pad_in_dat = '0; pad_in_vld = 1'b0; core_in_rdy = 1'b0;
    core_out_dat = '0; core_out_vld = 1'b0; pad_out_rdy = 1'b0;
    #2 arst_n = 1'b0;

    // reset / idle
    repeat (3) tick();
    chk("rst_core_in_vld", core_in_vld, 0);
    chk("rst_core_in_dat", core_in_dat, 0);
    chk("rst_pad_in_rdy", pad_in_rdy, 0);
    chk("rst_pad_out_vld", pad_out_vld, 0);
    chk("rst_pad_out_last", pad_out_last, 0);
    chk("rst_pad_out_dat", pad_out_dat, 0);
    chk("rst_core_out_rdy", core_out_rdy, 0);
    chk("rst_fifo_level", fifo_level, 0);
    arst_n = 1'b1;
    chk("rel_pad_in_rdy_hold", pad_in_rdy, 0);
    tick();
    chk("rel_pad_in_rdy", pad_in_rdy, 1);
    chk("rel_core_out_rdy", core_out_rdy, 1);

    // assembly 0x123
    pad_in_vld = 1'b1;
    pad_in_dat = 4'h3; tick();
    pad_in_dat = 4'h2; tick();
    pad_in_dat = 4'h1; tick();
    pad_in_vld = 1'b0;
    chk("asm_vld", core_in_vld, 1);
    chk("asm_dat", core_in_dat, 12'h123);
    chk("asm_rdy_low", pad_in_rdy, 0);
    pad_in_vld = 1'b1; pad_in_dat = 4'hF;  // must be ignored while holding
    repeat (2) tick();
    chk("hold_vld", core_in_vld, 1);
    chk("hold_dat", core_in_dat, 12'h123);
    pad_in_vld = 1'b0;
    core_in_rdy = 1'b1; tick(); core_in_rdy = 1'b0;
    chk("acc_vld_low", core_in_vld, 0);
    chk("acc_rdy_high", pad_in_rdy, 1);
    pad_in_vld = 1'b1;
    pad_in_dat = 4'h7; tick();
    pad_in_dat = 4'h8; tick();
    pad_in_dat = 4'h9; tick();
    pad_in_vld = 1'b0;
    chk("asm2_dat", core_in_dat, 12'h987);
    chk("asm2_vld", core_in_vld, 1);
    core_in_rdy = 1'b1; tick(); core_in_rdy = 1'b0;

    // serialisation of one pixel
    pad_out_rdy = 1'b1;
    core_out_dat = 24'hAABBCC; core_out_vld = 1'b1; tick(); core_out_vld = 1'b0;
    chk("ser_wait_vld", pad_out_vld, 0);
    tick();
    chk("ser_b0_vld", pad_out_vld, 1);
    chk("ser_b0_dat", pad_out_dat, 8'hCC);
    chk("ser_b0_last", pad_out_last, 0);
    chk("ser_level0", fifo_level, 0);
    tick();
    chk("ser_b1_dat", pad_out_dat, 8'hBB);
    chk("ser_b1_last", pad_out_last, 0);
    tick();
    chk("ser_b2_dat", pad_out_dat, 8'hAA);
    chk("ser_b2_last", pad_out_last, 1);
    tick();
    chk("ser_done_vld", pad_out_vld, 0);
    chk("ser_done_last", pad_out_last, 0);

    // full / backpressure
    pad_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      core_out_dat = pix[i]; core_out_vld = 1'b1; tick();
    end
    core_out_vld = 1'b0;
    chk("full_level", fifo_level, 4);
    chk("full_rdy", core_out_rdy, 0);
    chk("full_ser_vld", pad_out_vld, 1);
    chk("full_ser_dat", pad_out_dat, 8'h33);
    core_out_dat = 24'hEEEEEE; core_out_vld = 1'b1; tick(); core_out_vld = 1'b0;
    chk("full_drop_level", fifo_level, 4);
    pad_out_rdy = 1'b1;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++) begin
        chk("drain_vld", pad_out_vld, 1);
        chk("drain_dat", pad_out_dat, 32'((pix[p] >> (8*b)) & 24'hFF));
        chk("drain_last", pad_out_last, (b == 2) ? 1 : 0);
        tick();
      end
    end
    chk("drain_end_vld", pad_out_vld, 0);
    chk("drain_end_rdy", core_out_rdy, 1);

    // stall stability with random pad_out_rdy
    pad_out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_out_dat = spix[i]; core_out_vld = 1'b1; tick();
      for (int b = 0; b < 3; b++) exp_b[i*3+b] = 8'((spix[i] >> (8*b)) & 24'hFF);
    end
    core_out_vld = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 9 && cyc < 300) begin
      chk("stall_vld", pad_out_vld, 1);
      chk("stall_dat", pad_out_dat, exp_b[idx]);
      chk("stall_last", pad_out_last, (idx % 3 == 2) ? 1 : 0);
      pad_out_rdy = 1'($urandom_range(0, 1));
      acc = pad_out_vld & pad_out_rdy;
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("stall_beats", idx, 9);
    chk("stall_end_vld", pad_out_vld, 0);

    // flush mid-word and mid-pixel
    pad_out_rdy = 1'b0;
    pad_in_vld = 1'b1;
    core_out_vld = 1'b1;
    pad_in_dat = 4'hF; core_out_dat = 24'h010203; tick();
    pad_in_dat = 4'hE; core_out_dat = 24'h040506; tick();
    pad_in_vld = 1'b0; core_out_vld = 1'b0;
    pad_out_rdy = 1'b1; tick(); pad_out_rdy = 1'b0;
    chk("pre_flush_dat", pad_out_dat, 8'h02);
    chk("pre_flush_level", fifo_level, 1);
    chk("pre_flush_in_vld", core_in_vld, 0);
    flush = 1'b1; pad_in_vld = 1'b1; pad_in_dat = 4'h5;
    core_out_vld = 1'b1; core_out_dat = 24'h0A0B0C;
    tick();
    flush = 1'b0; pad_in_vld = 1'b0; core_out_vld = 1'b0;
    chk("flush_core_in_vld", core_in_vld, 0);
    chk("flush_pad_out_vld", pad_out_vld, 0);
    chk("flush_pad_out_last", pad_out_last, 0);
    chk("flush_level", fifo_level, 0);
    chk("flush_pad_in_rdy", pad_in_rdy, 1);
    chk("flush_core_out_rdy", core_out_rdy, 1);
    repeat (2) tick();
    chk("flush_stays_idle", pad_out_vld, 0);
    pad_in_vld = 1'b1;
    pad_in_dat = 4'h6; tick();
    pad_in_dat = 4'h5; tick();
    chk("post_flush_mid", core_in_vld, 0);
    pad_in_dat = 4'h4; tick();
    pad_in_vld = 1'b0;
    chk("post_flush_dat", core_in_dat, 12'h456);
    chk("post_flush_vld", core_in_vld, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
